// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
package seg7_pkg;

    // Width of one packed BCD digit
    localparam int BCD_W = 4;

    // Segment pattern with every segment off
    localparam logic [6:0] SEG_BLANK = 7'b0;

    // Scan FSM: GUARD blanks the start of a slot, DRIVE lights the digit
    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bcd7seg.sv
// BCD to 7-segment decoder, segments ordered {a,b,c,d,e,f,g}, active high.
module bcd7seg
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Pure lookup; codes above 9 decode to all-off
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 7'b1111110;
            4'd1: seg = 7'b0110000;
            4'd2: seg = 7'b1101101;
            4'd3: seg = 7'b1111001;
            4'd4: seg = 7'b0110011;
            4'd5: seg = 7'b1011011;
            4'd6: seg = 7'b1011111;
            4'd7: seg = 7'b1110000;
            4'd8: seg = 7'b1111111;
            4'd9: seg = 7'b1111011;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed multi-digit 7-segment scan controller with a
// frame-synchronous double-buffered value register.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    output logic                      ready,
    input  logic [BCD_W*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]         dp_in,
    input  logic                      lzb_en,
    output logic [DIGITS-1:0]         dig_en,
    output logic [6:0]                seg,
    output logic                      dp
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx, idx_nxt;
    state_t        state, state_nxt;
    logic          slot_end, boundary, accept;

    logic [DIGITS-1:0][BCD_W-1:0] act_val, act_nxt, pend_val;
    logic [DIGITS-1:0]            act_dp, act_dp_nxt, pend_dp;
    logic                         pend_flag, flag_nxt;

    logic [DIGITS-1:0] lz;
    logic [BCD_W-1:0]  cur_code;
    logic [6:0]        dec_seg;
    logic              blank;

    logic [DIGITS-1:0] en_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;

    // Slot counter and digit index advance
    always_comb begin
        slot_end = (cnt == CW'(PRESCALE - 1));
        boundary = slot_end && (idx == IW'(DIGITS - 1));
        cnt_nxt  = slot_end ? '0 : cnt + CW'(1);
        idx_nxt  = idx;
        if (slot_end)
            idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end

    // Next-state logic; >= lets a zero guard length fall straight into DRIVE
    always_comb begin
        state_nxt = state;
        case (state)
            GUARD: if (cnt_nxt >= CW'(BLANK_CYCLES)) state_nxt = DRIVE;
            DRIVE: if (slot_end && BLANK_CYCLES != 0) state_nxt = GUARD;
            default: state_nxt = GUARD;
        endcase
    end

    // Handshake and frame-boundary transfer of pending into active
    always_comb begin
        accept     = load && ready;
        flag_nxt   = accept || (pend_flag && !boundary);
        act_nxt    = act_val;
        act_dp_nxt = act_dp;
        if (boundary && pend_flag) begin
            act_nxt    = pend_val;
            act_dp_nxt = pend_dp;
        end
    end

    // Leading-zero map: lz[i] means digit i and all above it are zero
    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run   = run && (act_nxt[i] == '0);
            lz[i] = run;
        end
    end

    // Select the digit for the upcoming cycle and decide whether to blank it.
    // Looking at next-cycle data keeps registered outputs aligned with the counter.
    always_comb begin
        cur_code = act_nxt[idx_nxt];
        blank    = (cur_code > BCD_W'(9)) ||
                   (lzb_en && lz[idx_nxt] && (idx_nxt != '0));
    end

    bcd7seg u_dec (
        .bcd (cur_code),
        .seg (dec_seg)
    );

    // Output values to be registered on the next edge
    always_comb begin
        en_nxt  = '0;
        seg_nxt = SEG_BLANK;
        dp_nxt  = 1'b0;
        if (state_nxt == DRIVE) begin
            en_nxt  = DIGITS'(1) << idx_nxt;
            seg_nxt = blank ? SEG_BLANK : dec_seg;
            dp_nxt  = act_dp_nxt[idx_nxt];
        end
    end

    // Scan timing and FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            state <= GUARD;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= state_nxt;
        end
    end

    // Pending and active display buffers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            act_val   <= '0;
            act_dp    <= '0;
        end else begin
            if (accept) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end
            pend_flag <= flag_nxt;
            act_val   <= act_nxt;
            act_dp    <= act_dp_nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready  <= 1'b1;
            dig_en <= '0;
            seg    <= SEG_BLANK;
            dp     <= 1'b0;
        end else begin
            ready  <= !flag_nxt;
            dig_en <= en_nxt;
            seg    <= seg_nxt;
            dp     <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: table vectors, handshake/boundary/reset
// sequences and randomized traffic against a frame-level reference model.
module tb_seg7_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        ready;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        lzb_en = 1'b0;
    logic [3:0]  dig_en;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan_ctrl #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .ready  (ready),
        .value  (value),
        .dp_in  (dp_in),
        .lzb_en (lzb_en),
        .dig_en (dig_en),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles since reset release, buffers, handshake flag
    int          m_n;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    logic        m_flag, m_lzb;

    // Inputs held by the stimulus sequences
    logic [15:0] h_val;
    logic [3:0]  h_dp;
    logic        h_lzb;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpv;
        logic            lzb;
        logic [3:0][6:0] segs;
    } vec_t;
    vec_t tv[6];

    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;
            3: return 7'h79;  4: return 7'h33;  5: return 7'h5B;
            6: return 7'h5F;  7: return 7'h70;  8: return 7'h7F;
            9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    // Digit d is blanked when invalid, or under LZB when it and all higher digits are zero
    function automatic logic [6:0] model_seg(input int d);
        int code;
        code = int'((m_act >> (4 * d)) & 16'hF);
        if (code > 9) return 7'h00;
        if (m_lzb && d != 0 && (m_act >> (4 * d)) == 16'h0) return 7'h00;
        return seg_of(code);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s n=%0d actual=%0h expected=%0h", name, m_n, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s timeout n=%0d", name, m_n);
    endtask

    task automatic model_reset();
        m_n = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0;
        m_flag = 1'b0; m_lzb = 1'b0;
    endtask

    task automatic check_outputs();
        int  off, d;
        bit  drv;
        off = m_n % PRESCALE;
        d   = (m_n / PRESCALE) % DIGITS;
        drv = (off >= BLANK);
        check("dig_en", 32'(dig_en), drv ? (32'd1 << d) : 32'd0);
        check("seg",    32'(seg),    drv ? 32'(model_seg(d)) : 32'd0);
        check("dp",     32'(dp),     drv ? 32'(m_adp[d]) : 32'd0);
        check("ready",  32'(ready),  32'(!m_flag));
    endtask

    // One clock: drive inputs, update the model at the edge, compare at negedge
    task automatic tick(input logic ld);
        bit boundary;
        load = ld; value = h_val; dp_in = h_dp; lzb_en = h_lzb;
        @(posedge clk);
        boundary = ((m_n % FRAME) == FRAME - 1);
        if (ld && !m_flag) begin
            m_pend = h_val; m_pdp = h_dp; m_flag = 1'b1;
        end else if (boundary && m_flag) begin
            m_act = m_pend; m_adp = m_pdp; m_flag = 1'b0;
        end
        m_lzb = h_lzb;
        m_n++;
        @(negedge clk);
        load = 1'b0;
        check_outputs();
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 2 * FRAME && m_flag; k++) tick(1'b0);
        if (m_flag) timeout("wait_ready");
    endtask

    task automatic wait_frame_start();
        for (int k = 0; k < 3 * FRAME && (m_flag || (m_n % FRAME) != 0); k++) tick(1'b0);
        if (m_flag || (m_n % FRAME) != 0) timeout("wait_frame");
    endtask

    task automatic advance_to(input int pos);
        for (int k = 0; k < FRAME && (m_n % FRAME) != pos; k++) tick(1'b0);
    endtask

    initial begin
        tv[0] = '{16'h1234, 4'b0100, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}};
        tv[1] = '{16'h0045, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h33, 7'h5B}};
        tv[2] = '{16'h0000, 4'b1001, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
        tv[3] = '{16'h00A1, 4'b0010, 1'b0, {7'h7E, 7'h7E, 7'h00, 7'h30}};
        tv[4] = '{16'h0809, 4'b0000, 1'b1, {7'h00, 7'h7F, 7'h7E, 7'h7B}};
        tv[5] = '{16'h00A1, 4'b1111, 1'b1, {7'h00, 7'h00, 7'h00, 7'h30}};

        model_reset();
        h_val = '0; h_dp = '0; h_lzb = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        tick(1'b0);
        tick(1'b0);
        check("first_drive", 32'(dig_en), 32'd1);

        // Table vectors: load, wait for the frame that shows it, check each drive cycle
        foreach (tv[i]) begin
            h_val = tv[i].val; h_dp = tv[i].dpv; h_lzb = tv[i].lzb;
            wait_ready();
            tick(1'b1);
            wait_frame_start();
            for (int k = 1; k < FRAME; k++) begin
                int off, d;
                tick(1'b0);
                off = m_n % PRESCALE;
                d   = (m_n / PRESCALE) % DIGITS;
                if (off >= BLANK) begin
                    check("tv_en",  32'(dig_en), 32'd1 << d);
                    check("tv_seg", 32'(seg),    32'(tv[i].segs[d]));
                    check("tv_dp",  32'(dp),     32'(tv[i].dpv[d]));
                end
            end
        end

        // A load while not ready must not overwrite pending
        h_val = 16'h1111; h_dp = 4'b0000; h_lzb = 1'b0;
        wait_ready();
        advance_to(10);
        tick(1'b1);
        check("hs_ready", 32'(ready), 32'd0);
        h_val = 16'h2222;
        tick(1'b1);
        wait_frame_start();
        advance_to(3 * PRESCALE + 2);
        check("hs_1111", 32'(seg), 32'h30);

        // Accept on the boundary cycle defers display by one more frame
        h_val = 16'h3333;
        advance_to(FRAME - 1);
        tick(1'b1);
        check("bd_ready", 32'(ready), 32'd0);
        advance_to(2);
        check("bd_old", 32'(seg), 32'h30);
        tick(1'b0);
        advance_to(2);
        check("bd_new", 32'(seg), 32'h79);

        // Asynchronous reset mid-DRIVE with pending data outstanding
        h_val = 16'h5678;
        tick(1'b1);
        advance_to(PRESCALE + 4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_en",    32'(dig_en), 32'd0);
        check("rst_seg",   32'(seg),    32'd0);
        check("rst_dp",    32'(dp),     32'd0);
        check("rst_ready", 32'(ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_outputs();
        tick(1'b0);
        check("rst_guard", 32'(dig_en), 32'd0);
        tick(1'b0);
        check("rst_first", 32'(dig_en), 32'd1);

        // Randomized traffic checked cycle by cycle against the model
        for (int k = 0; k < 600; k++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            h_val = 16'($urandom) & mask;
            h_dp  = 4'($urandom);
            if (k % 16 == 0) h_lzb = 1'($urandom);
            tick(($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
